serial_transmitter: RTL
=======================

# serial_transmitter

Frame-based serial transmitter: it accepts one parallel byte on a Start strobe, holds it internally and shifts it out LSB-first on a single line. The line carries a start bit, the data bits and a stop bit, each held for a fixed number of clock cycles. The block sits on the sending side of the lab serial link and drives the line that the matching receiver samples. Its output and control registers are storage elements built in the same flip-flop style as the lab latches and flip-flops.

## Interface
Parameters:
- CLKS_PER_BIT, 4, clock cycles each bit is held on Tx; legal values ≥ 2.
- DATA_W, 8, data bits per frame.

Ports:
- Clk, input, 1, single clock; all state updates on the rising edge.
- Rst, input, 1, synchronous, active-high reset, sampled on the rising edge of Clk.
- Start, input, 1, request to send Data; sampled on the rising edge.
- Data, input, DATA_W, byte to send; captured only on the accepting edge.
- Tx, output, 1, serial line; idle level is high.
- Busy, output, 1, high while a frame is in progress.
- Done, output, 1, one-cycle pulse when a frame completes.

## Operation
- State machine states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE:**
  - Tx=1, Busy=0.
  - If Start=1 at an edge, capture Data into a shift register, clear the bit and cycle counters, and go to START.
- **START:** Tx=0 for CLKS_PER_BIT cycles.
- **DATA:**
  - Tx = shift_reg[0].
  - After CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After DATA_W bits, go to PARITY (if compiled in) or STOP.
- **STOP:** Tx=1 for CLKS_PER_BIT cycles, then go to IDLE with a one-cycle Done pulse.
- **Start while Busy=1:** ignored entirely; the captured byte is unaffected.
- **Data changes after acceptance:** no effect on the frame in progress.
- **Reset mid-frame:** at the next edge, the frame is abandoned. The block enters IDLE with Tx=1, Busy=0, Done=0, and counters cleared. No partial Done.
- **Rst and Start asserted together:** Rst wins and nothing is accepted.
- **Reset values:** Tx=1, Busy=0, Done=0, state=IDLE, cycle counter=0, bit index=0, shift register=0.
- **Counter widths:**
  - Cycle counter: $clog2(CLKS_PER_BIT) bits, wraps to 0 at CLKS_PER_BIT-1.
  - Bit index: $clog2(DATA_W+1) bits.

## Timing
- Tx, Busy and Done are all registered; there are no combinational paths from inputs to outputs.
- **Acceptance:** Start is sampled high at edge k while Busy=0.
  - From edge k, Busy=1 and Tx=0.
  - Tx bit n (start bit = 0) is valid for cycles k+n·C … k+(n+1)·C−1, where C=CLKS_PER_BIT.
- **Frame length:**
  - (DATA_W+2)·C cycles, i.e. 40 cycles at the defaults.
  - (DATA_W+3)·C cycles with parity.
- **Completion:** at edge k+len, Busy=0 and Done=1 for exactly one cycle, and Tx=1.
- **Back-to-back frames:**
  - A Start held high during the Done cycle is accepted at the following edge.
  - The minimum inter-frame gap is one idle cycle with Tx=1.
- **Throughput:** one frame per len+1 cycles when Start is held high continuously.

## Configuration
- Macro: SERIAL_TX_PARITY_EN.
- **Defined:**
  - A PARITY state is inserted after DATA, lasting C cycles.
  - Tx = even parity, the XOR of the captured data bits.
  - The frame grows by C cycles.
- **Undefined:** DATA goes directly to STOP, and no parity logic is synthesized.

## Structure
- **Shared package `serial_pkg` (include header):**
  - State encodings ST_IDLE=0, ST_START=1, ST_DATA=2, ST_PARITY=3, ST_STOP=4 (3-bit state).
  - Line levels LINE_IDLE=1'b1, START_BIT=1'b0.
  - Default CLKS_PER_BIT and DATA_W.
  - The receiver uses the same package.
- **Sub-module `bit_timer`:**
  - Cycle counter parameterized by CLKS_PER_BIT.
  - Inputs: Clk, Rst, Clear.
  - Output: Tick, high during the last cycle of each bit period.
  - The FSM advances only on Tick.

## Test plan
All scenarios use defaults (C=4, DATA_W=8) and parity off unless stated.
1. **Reset values:** hold Rst 2 cycles → Tx=1, Busy=0, Done=0. Idle 10 cycles with Start=0 → outputs unchanged.
2. **Send 8'hA5:** Start pulse at edge k → Tx per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1. Busy is high for cycles k…k+39. Done=1 only at cycle k+40.
3. **Ignore while busy:** during the A5 frame, pulse Start with Data=8'hFF at cycle k+12 and change Data → Tx sequence identical to scenario 2, no second frame, and a single Done.
4. **Reset mid-frame:** assert Rst at cycle k+18 → next cycle Tx=1, Busy=0, and Done never pulses. A new Start for 8'h3C afterwards sends 0,0,0,1,1,1,1,0,0,1.
5. **Back-to-back:** hold Start=1 with 8'h01 then 8'h80 → second start bit at cycle k+41, two Done pulses 41 cycles apart.
6. **Parity (SERIAL_TX_PARITY_EN defined):** send 8'h01 → slots 0,1,0,0,0,0,0,0,0,1(parity),1(stop), Done at k+44. Send 8'hA5 → parity slot 0.

Source files
------------

// File: rtl/serial_pkg.sv
// ============================================================================
// Module  : serial_pkg
// Purpose : Shared encodings and defaults for the serial link (tx and rx).
// Rev     : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam int DEFAULT_CLKS_PER_BIT = 4;
  localparam int DEFAULT_DATA_W       = 8;

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
// ============================================================================
// Module  : bit_timer
// Purpose : Bit-period counter; Tick marks the last cycle of each period.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clear,
  output logic Tick
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (Clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Tick = (cnt_q == LAST) && !Clear;

endmodule

`default_nettype wire

// File: rtl/serial_transmitter.sv
// ============================================================================
// Module  : serial_transmitter
// Purpose : LSB-first framed serial transmitter (start, data, [parity], stop).
//           Optional even parity bit enabled by SERIAL_TX_PARITY_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module serial_transmitter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = DEFAULT_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [DATA_W-1:0] Data,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  localparam int              BI_W     = $clog2(DATA_W + 1);
  localparam logic [BI_W-1:0] LAST_BIT = BI_W'(DATA_W - 1);

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [BI_W-1:0]   bit_idx_q, bit_idx_d;
  logic              tx_q,      tx_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q,  parity_d;
`endif

  logic tick;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .Clk   (Clk),
    .Rst   (Rst),
    .Clear (state_q == ST_IDLE),
    .Tick  (tick)
  );

  // Outputs are registered, so tx_d holds the level of the state being entered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
        if (Start) begin
          state_d   = ST_START;
          shift_d   = Data;
          bit_idx_d = '0;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^Data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + BI_W'(1);
          tx_d      = shift_d[0];
          if (bit_idx_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = LINE_IDLE;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = LINE_IDLE;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          tx_d    = LINE_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

`default_nettype wire
